// File: rtl/tdc_code_averager_if.sv
// Result bus for tdc_code_averager: window average, min, max and alarm,
// published through avg_valid / avg_ready. master = averager, slave = consumer.
interface tdc_code_averager_if;
   logic [4:0] avg_out;
   logic [4:0] min_out;
   logic [4:0] max_out;
   logic       alarm;
   logic       avg_valid;
   logic       avg_ready;

   modport master (
      output avg_out, min_out, max_out, alarm, avg_valid,
      input  avg_ready
   );

   modport slave (
      input  avg_out, min_out, max_out, alarm, avg_valid,
      output avg_ready
   );
endinterface

// File: rtl/tdc_code_averager.sv
// Bubble-corrects 16-tap edge words to 0..16 codes and averages them
// per 2^AVG_LOG2 window with min/max, alarm and sticky saturation flags.
// Ports: CLK, RST (async low), en, clr, samp_valid, EDGE_IN[1:16] in;
// code, code_valid, sat_lo, sat_hi, overrun out; res = window result bus.
module tdc_code_averager #(
   parameter int AVG_LOG2 = 3,
   parameter int THRESH   = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  en,
   input  logic                  clr,
   input  logic                  samp_valid,
   input  logic [1:16]           EDGE_IN,
   output logic [4:0]            code,
   output logic                  code_valid,
   output logic                  sat_lo,
   output logic                  sat_hi,
   output logic                  overrun,
   tdc_code_averager_if.master   res
);
   localparam int AW = 5 + AVG_LOG2;
   localparam int CW = AVG_LOG2 + 1;
   localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);
   localparam logic [4:0] THR = 5'(THRESH);

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_PUB} state_t;

   state_t        state_q, state_d;
   logic          s1_vld_q;
   logic [1:16]   s1_word_q;
   logic [4:0]    code_q;
   logic          code_vld_q;
   logic          sat_lo_q, sat_hi_q, ovr_q;
   logic [AW-1:0] acc_q, acc_d, acc_b;
   logic [CW-1:0] cnt_q, cnt_d, cnt_b;
   logic [4:0]    min_q, min_d, max_q, max_d;
   logic [4:0]    avg_q, omin_q, omax_q, avg_d;
   logic          alarm_q, avg_vld_q;
   logic [0:17]   r;
   logic [4:0]    pop_d;

   // Taps padded so the edge start reads 1 and the far end reads 0.
   always_comb begin
      r     = {1'b1, s1_word_q, 1'b0};
      pop_d = '0;
      for (int k = 1; k <= 16; k++) begin
         pop_d = pop_d + 5'((r[k-1] & r[k]) | (r[k] & r[k+1])
                            | (r[k-1] & r[k+1]));
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         s1_vld_q   <= 1'b0;
         s1_word_q  <= '0;
         code_q     <= '0;
         code_vld_q <= 1'b0;
         sat_lo_q   <= 1'b0;
         sat_hi_q   <= 1'b0;
      end else if (clr) begin
         s1_vld_q   <= 1'b0;
         code_vld_q <= 1'b0;
         sat_lo_q   <= 1'b0;
         sat_hi_q   <= 1'b0;
      end else begin
         s1_vld_q   <= samp_valid;
         code_vld_q <= s1_vld_q;
         if (samp_valid) s1_word_q <= EDGE_IN;
         if (s1_vld_q) begin
            code_q <= pop_d;
            if (pop_d == 5'd0)  sat_lo_q <= 1'b1;
            if (pop_d == 5'd16) sat_hi_q <= 1'b1;
         end
      end
   end

   // In PUB the finished window is being published, so a sample
   // arriving now starts the next window from an empty base.
   always_comb begin
      state_d = state_q;
      acc_b   = (state_q == S_PUB) ? '0 : acc_q;
      cnt_b   = (state_q == S_PUB) ? '0 : cnt_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      min_d   = min_q;
      max_d   = max_q;
      case (state_q)
         S_IDLE: begin
            acc_d = '0;
            cnt_d = '0;
            min_d = '0;
            max_d = '0;
            if (en) state_d = S_ACCUM;
         end
         S_ACCUM, S_PUB: begin
            if (!en) begin
               state_d = S_IDLE;
               acc_d   = '0;
               cnt_d   = '0;
               min_d   = '0;
               max_d   = '0;
            end else begin
               state_d = S_ACCUM;
               acc_d   = acc_b;
               cnt_d   = cnt_b;
               if (code_vld_q) begin
                  acc_d = acc_b + AW'(code_q);
                  cnt_d = cnt_b + CW'(1);
                  if (cnt_b == '0 || code_q < min_q) min_d = code_q;
                  if (cnt_b == '0 || code_q > max_q) max_d = code_q;
                  if (cnt_b == LAST) state_d = S_PUB;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (clr) begin
         state_d = S_IDLE;
         acc_d   = '0;
         cnt_d   = '0;
         min_d   = '0;
         max_d   = '0;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         min_q   <= '0;
         max_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         min_q   <= min_d;
         max_q   <= max_d;
      end
   end

   assign avg_d = 5'(acc_q >> AVG_LOG2);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         avg_q     <= '0;
         omin_q    <= '0;
         omax_q    <= '0;
         alarm_q   <= 1'b0;
         avg_vld_q <= 1'b0;
         ovr_q     <= 1'b0;
      end else if (clr) begin
         alarm_q   <= 1'b0;
         avg_vld_q <= 1'b0;
         ovr_q     <= 1'b0;
      end else if (state_q == S_PUB) begin
         avg_q     <= avg_d;
         omin_q    <= min_q;
         omax_q    <= max_q;
         alarm_q   <= (avg_d < THR);
         avg_vld_q <= 1'b1;
         if (avg_vld_q && !res.avg_ready) ovr_q <= 1'b1;
      end else if (res.avg_ready) begin
         avg_vld_q <= 1'b0;
      end
   end

   assign code          = code_q;
   assign code_valid    = code_vld_q;
   assign sat_lo        = sat_lo_q;
   assign sat_hi        = sat_hi_q;
   assign overrun       = ovr_q;
   assign res.avg_out   = avg_q;
   assign res.min_out   = omin_q;
   assign res.max_out   = omax_q;
   assign res.alarm     = alarm_q;
   assign res.avg_valid = avg_vld_q;
endmodule
